// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low g..a patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scanner with blank/drive phases per digit and
// frame-boundary commit of new display data.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned BLANK_TICKS = 1,
    parameter int unsigned DRIVE_TICKS = 14,
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    tick_en,
    input  logic                    enable,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic                    load_ready,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam int unsigned MAX_TICKS = (BLANK_TICKS > DRIVE_TICKS) ? BLANK_TICKS : DRIVE_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLANK_TICKS < 1 || DRIVE_TICKS < 1) begin : g_param_check
        $error("seg_scan_controller: illegal NUM_DIGITS/BLANK_TICKS/DRIVE_TICKS");
    end

    scan_state_t             state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    frame_nxt;
    logic                    boundary;
    logic [4*NUM_DIGITS-1:0] active_data, pend_data;
    logic [NUM_DIGITS-1:0]   active_dp, pend_dp;
    logic                    pend_flag, pend_nxt;
    logic                    transfer, commit;
    logic [NUM_DIGITS-1:0]   anode_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;
    logic [6:0]              seg_dec_c;

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (active_data[{digit_idx, 2'b00} +: 4]),
        .seg_c  (seg_dec_c)
    );

    // Scan sequencing; disable overrides any tick in the same cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = digit_idx;
        frame_nxt = 1'b0;
        boundary  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick_en) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                    end
                end
                BLANK: begin
                    if (tick_en) begin
                        if (cnt == BLANK_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = DRIVE;
                        end else begin
                            cnt_nxt = CNT_W'(cnt + 1'b1);
                        end
                    end
                end
                DRIVE: begin
                    if (tick_en) begin
                        if (cnt == DRIVE_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = BLANK;
                            if (digit_idx == IDX_LAST) begin
                                idx_nxt   = '0;
                                frame_nxt = 1'b1;
                                boundary  = 1'b1;
                            end else begin
                                idx_nxt = IDX_W'(digit_idx + 1'b1);
                            end
                        end else begin
                            cnt_nxt = CNT_W'(cnt + 1'b1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Handshake and tear-free commit; transfer and commit are mutually exclusive
    always_comb begin
        transfer = load_valid && load_ready;
        commit   = pend_flag && (boundary || state == IDLE);
        pend_nxt = pend_flag;
        if (transfer) begin
            pend_nxt = 1'b1;
        end else if (commit) begin
            pend_nxt = 1'b0;
        end
    end

    // Display drive, registered one cycle behind the scan state
    always_comb begin
        anode_nxt = '1;
        seg_nxt   = SEG_BLANK;
        dp_nxt    = 1'b1;
        if (state == DRIVE) begin
            anode_nxt[digit_idx] = 1'b0;
            seg_nxt              = seg_dec_c;
            dp_nxt               = ~active_dp[digit_idx];
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            digit_idx   <= '0;
            frame_done  <= 1'b0;
            load_ready  <= 1'b1;
            pend_flag   <= 1'b0;
            pend_data   <= '0;
            pend_dp     <= '0;
            active_data <= '0;
            active_dp   <= '0;
            anode_n     <= '1;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            digit_idx  <= idx_nxt;
            frame_done <= frame_nxt;
            pend_flag  <= pend_nxt;
            load_ready <= ~pend_nxt;
            if (transfer) begin
                pend_data <= load_data;
                pend_dp   <= load_dp;
            end
            if (commit) begin
                active_data <= pend_data;
                active_dp   <= pend_dp;
            end
            anode_n <= anode_nxt;
            seg_n   <= seg_nxt;
            dp_n    <= dp_nxt;
        end
    end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Multiplexed seven-segment scan controller for the RGB-PWM board display. It consumes the one-cycle tick enable from the board's clock-divider block and sequences the shared segment bus across NUM_DIGITS anodes. Each digit gets a blanking interval followed by a drive interval, to suppress ghosting. New display data arrives on a valid/ready handshake and is committed only at a frame boundary, so a frame is never torn.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (legal 1..8)
BLANK_TICKS, 1, tick_en pulses per blanking interval (>=1)
DRIVE_TICKS, 14, tick_en pulses per digit drive interval (>=1)

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
tick_en  in  1  one-cycle scan tick pulse from the clock-divider block
enable  in  1  1 = scan, 0 = display blank/idle
load_valid  in  1  new display data offered
load_data  in  4*NUM_DIGITS  hex nibbles; digit i = [4i+3:4i]
load_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
load_ready  out  1  controller can accept load_data
anode_n  out  NUM_DIGITS  digit select, active-low
seg_n  out  7  segments g..a (bit0 = a), active-low
dp_n  out  1  decimal point, active-low
digit_idx  out  $clog2(NUM_DIGITS) (min 1)  digit currently blanked or driven
frame_done  out  1  one-cycle pulse at end of the last digit's drive interval

Behaviour:
- Reset values: state IDLE; anode_n all 1; seg_n 7'h7F; dp_n 1; digit_idx 0; frame_done 0; load_ready 1; active and pending registers 0; pending flag 0; tick counter 0.
- States: IDLE, BLANK, DRIVE (enum).
- IDLE -> BLANK on enable && tick_en. Digit_idx and tick counter are 0 on entry.
- BLANK: tick counter increments only on tick_en. On the tick where cnt == BLANK_TICKS-1: cnt <= 0 and go to DRIVE.
- DRIVE: on the tick where cnt == DRIVE_TICKS-1: cnt <= 0 and go to BLANK.
  - If digit_idx == NUM_DIGITS-1: digit_idx <= 0, frame_done pulses one cycle, and the frame commit happens.
  - Otherwise: digit_idx increments.
- enable == 0 in any state: next cycle state IDLE, digit_idx 0, cnt 0. This takes priority over tick_en in the same cycle.
- Output latency: anode_n, seg_n and dp_n are registered and lag the state register by exactly 1 sys_clk.
  - In IDLE and BLANK they are all-off.
  - In DRIVE: anode_n[digit_idx] = 0, others 1; seg_n = hex decode of the active nibble; dp_n = ~active_dp[digit_idx].
- frame_done and digit_idx come directly from registers, with no extra lag.
- Handshake:
  - A transfer occurs when load_valid && load_ready.
  - On transfer, load_data and load_dp are captured into the pending register, the pending flag is set, and load_ready is 0 from the next cycle.
  - Commit means active <= pending, pending flag cleared, load_ready 1 on the following cycle.
  - Commit happens at a frame boundary, or in any cycle spent in IDLE while the pending flag is set.
- Simultaneous events:
  - A transfer in the same cycle as a frame boundary with no pending data: the boundary commits nothing, and the new data commits at the next boundary.
  - load_valid held while load_ready = 0: no capture, and data is held by the source.
- Hex decode (g..a, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Counter width: $clog2(max(BLANK_TICKS, DRIVE_TICKS)+1). Illegal parameters raise an elaboration-time assertion.
- Reset mid-scan: all registers return to reset values immediately (asynchronous); in-flight pending data is discarded.

Decomposition:
- Package seg_pkg holds the scan_state_t enum (IDLE/BLANK/DRIVE), the SEG_BLANK constant 7'h7F, and the 16-entry hex-to-segment constant table.
- One combinational sub-module, hex_to_seg7 (4-bit nibble in, 7-bit active-low segments out), built on the package table.
- Everything else lives in the top module.

Test Plan:
Use NUM_DIGITS = 4, BLANK_TICKS = 1, DRIVE_TICKS = 2, with tick_en every 4th cycle, for all scenarios.
1. Reset check: assert reset mid-scan -> anode_n = 4'hF, seg_n = 7'h7F, dp_n = 1, load_ready = 1, digit_idx = 0 within the same cycle.
2. Idle commit and scan: enable = 1, load 16'h1234 with dp = 4'b0001 while IDLE -> committed one cycle later; digit 0 drives seg_n = 0011001 ("4") with dp_n = 0 and anode_n = 1110; then digits 1..3 show 3, 2, 1; each drive lasts 8 cycles and each blank 4 cycles; frame_done pulses once per 48 cycles.
3. Tear-free update: load 16'hABCD mid-frame -> load_ready = 0 until the frame boundary; the remaining digits still show 1234 values; the next frame shows D, C, b, A.
4. Back-pressure: hold load_valid with new data while pending -> no capture until load_ready returns; exactly one transfer.
5. Disable mid-DRIVE: enable = 0 -> next cycle state IDLE and digit_idx = 0; outputs all-off one cycle later; re-enable restarts at digit 0 with BLANK.
6. Simultaneous boundary and load with no pending data: data becomes pending and displays only after the following frame_done.
